mul_seq_ctrl: RTL and testbench

- Handshake front-end and result-capture stage for the free-running 32x32 unsigned shift-add multiplier `mul_int`.
- Accepts operand pairs (signed or unsigned) on a valid/ready interface and converts them to magnitudes.
- Drives the magnitudes onto `mul_int` and holds them stable long enough to guarantee one complete 32-cycle multiply window, whatever phase `mul_int`'s internal counter is in.
- Samples `mul_int`'s 64-bit product, restores the sign and presents the result on a valid/ready output.

---
 rtl/mul_seq_ctrl.sv | 104 ++++++++++
 tb/tb_mul_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Valid/ready front-end and result capture for the free-running mul_int multiplier.
// Operands become magnitudes, are held for a full multiply window, then the sign is restored.
module mul_seq_ctrl #(
    parameter int HOLD_CYCLES = 66
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_signed,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_p,
    output logic        busy
);

    localparam int CW = $clog2(HOLD_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [CW-1:0] r_cnt;
    logic        r_neg;
    logic [31:0] r_mul_a;
    logic [31:0] r_mul_b;
    logic [63:0] r_out_p;
    logic        r_out_valid;

    logic        w_accept;
    logic        w_last;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    // The counter starts at 0 on the accept edge, so matching HOLD_CYCLES
    // puts the capture on the HOLD_CYCLES+1th edge after accept.
    assign w_last   = (r_state == S_HOLD) && (r_cnt == CW'(HOLD_CYCLES));
    assign w_mag_a  = (in_signed && in_a[31]) ? (~in_a + 32'd1) : in_a;
    assign w_mag_b  = (in_signed && in_b[31]) ? (~in_b + 32'd1) : in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_next = S_HOLD;
            S_HOLD: if (w_last)    w_next = S_DONE;
            S_DONE: if (out_ready) w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_out_p     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mul_a <= w_mag_a;
                r_mul_b <= w_mag_b;
                r_neg   <= in_signed & (in_a[31] ^ in_b[31]);
                r_cnt   <= '0;
            end
            if (r_state == S_HOLD) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last) begin
                r_out_p     <= r_neg ? (~mul_c + 64'd1) : mul_c;
                r_out_valid <= 1'b1;
            end
            if ((r_state == S_DONE) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_HOLD) || (r_state == S_DONE);
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign out_p     = r_out_p;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural free-running mul_int model attached.
module tb_mul_seq_ctrl;

    localparam int HOLD = 66;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_signed = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_c;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_p;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.HOLD_CYCLES(HOLD)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_a      (in_a),
        .in_b      (in_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_c     (mul_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    // mul_int stand-in: no reset, captures operands at phase 0, publishes at phase 31
    logic [4:0]  m_ph = 5'd13;
    logic [31:0] m_a  = '0;
    logic [31:0] m_b  = '0;
    logic [63:0] m_c  = 64'hDEAD_BEEF_0BAD_F00D;

    always @(posedge clk) begin
        m_ph <= m_ph + 5'd1;
        if (m_ph == 5'd0) begin
            m_a <= mul_a;
            m_b <= mul_b;
        end
        if (m_ph == 5'd31) begin
            m_c <= {32'd0, m_a} * {32'd0, m_b};
        end
    end
    assign mul_c = m_c;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid  = 1'b1;
        in_signed = sgn;
        in_a      = a;
        in_b      = b;
        chk("acc_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output logic saw_ready);
        lat = 0;
        saw_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (in_ready) saw_ready = 1'b1;
        end
        if (!out_valid) chk("timeout", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic run(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ema, input logic [31:0] emb, input logic [63:0] ep);
        int   lat;
        logic saw;
        accept(sgn, a, b);
        chk({tag, "_mul_a"}, {32'd0, mul_a}, {32'd0, ema});
        chk({tag, "_mul_b"}, {32'd0, mul_b}, {32'd0, emb});
        wait_result(lat, saw);
        chk({tag, "_lat"}, 64'(lat), 64'(HOLD + 1));
        chk({tag, "_rdy_low"}, {63'd0, saw}, 64'd0);
        chk({tag, "_p"}, out_p, ep);
        @(posedge clk);
        #1;
        chk({tag, "_ov_drop"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_idle"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        int   lat;
        logic saw;

        #12;
        chk("rst_ov", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ma", {32'd0, mul_a}, 64'd0);
        chk("rst_mb", {32'd0, mul_b}, 64'd0);
        chk("rst_p", out_p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", {63'd0, in_ready}, 64'd1);

        run("u3x5",    1'b0, 32'd3,         32'd5,         32'd3,         32'd5,         64'h0000_0000_0000_000F);
        run("sm3x5",   1'b1, 32'hFFFF_FFFD, 32'd5,         32'd3,         32'd5,         64'hFFFF_FFFF_FFFF_FFF1);
        run("umax",    1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run("smin2",   1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run("smin1",   1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000);
        run("sm5x0",   1'b1, 32'hFFFF_FFFB, 32'd0,         32'd5,         32'd0,         64'd0);
        run("umsb",    1'b0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFD, 32'd5,         64'h0000_0004_FFFF_FFF1);

        for (int k = 0; k < 32; k++) begin
            repeat (k) @(posedge clk);
            run("phase", 1'b0, 32'd7, 32'd9, 32'd7, 32'd9, 64'd63);
        end

        // backpressure: result must hold and a pending request must wait
        out_ready = 1'b0;
        accept(1'b0, 32'd11, 32'd13);
        wait_result(lat, saw);
        chk("bp_p", out_p, 64'd143);
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 32'd2;
        in_b = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_p", out_p, 64'd143);
            chk("bp_hold_ov", {63'd0, out_valid}, 64'd1);
            chk("bp_hold_rdy", {63'd0, in_ready}, 64'd0);
        end
        chk("bp_ma_kept", {32'd0, mul_a}, 64'd11);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_ov", {63'd0, out_valid}, 64'd0);
        chk("bp_idle_rdy", {63'd0, in_ready}, 64'd1);
        chk("bp_no_acc", {32'd0, mul_a}, 64'd11);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_acc_ma", {32'd0, mul_a}, 64'd2);
        chk("bp_acc_busy", {63'd0, busy}, 64'd1);
        wait_result(lat, saw);
        chk("bp_lat", 64'(lat), 64'(HOLD + 1));
        chk("bp_p2", out_p, 64'd6);
        @(posedge clk);
        #1;

        // asynchronous reset in the middle of a hold
        accept(1'b0, 32'd100, 32'd100);
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_ov", {63'd0, out_valid}, 64'd0);
        chk("mr_busy", {63'd0, busy}, 64'd0);
        chk("mr_ma", {32'd0, mul_a}, 64'd0);
        chk("mr_mb", {32'd0, mul_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_rdy", {63'd0, in_ready}, 64'd1);
        run("post_rst", 1'b0, 32'd2, 32'd2, 32'd2, 32'd2, 64'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
